// File: rtl/hv_rotate_sequencer.sv
// hv_rotate_sequencer
//   Rotates a hypervector right by an arbitrary amount. It takes several
//   cycles and uses one 0..63 position rotator stage per cycle. A request
//   (data + amount) comes in through a valid/ready handshake. The result
//   leaves through a second valid/ready handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | in_ready high, waiting for a request
//   ROTATE | one rotator pass per cycle until remaining amount is zero
//   DONE   | result presented on out_data, waiting for out_ready
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort back to IDLE (ignores same-cycle request)
//   in_valid/in_ready   request handshake
//   in_data, in_amount  hypervector and total right-rotation amount
//   out_valid/out_ready result handshake
//   out_data            rotated hypervector (zero while out_valid is low)
//   busy_cycles         saturating count of ROTATE cycles; the port exists
//                       only when HV_ROT_BUSY_CNT_EN is defined
//
// Build option: define HV_ROT_BUSY_CNT_EN to add the busy_cycles port.

module hv_rotate_sequencer #(
  parameter int HV_LENGTH = 256,
  parameter int ROT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HV_LENGTH-1:0] in_data,
  input  logic [ROT_WIDTH-1:0] in_amount,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [HV_LENGTH-1:0] out_data
`ifdef HV_ROT_BUSY_CNT_EN
  ,
  output logic [31:0]          busy_cycles
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROTATE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]             state_q;
  logic [HV_LENGTH-1:0]   data_q;
  logic [ROT_WIDTH-1:0]   remaining_q;

  logic [5:0]             step;
  logic [ROT_WIDTH-1:0]   remaining_next;
  logic [2*HV_LENGTH-1:0] rot_wide;
  logic [HV_LENGTH-1:0]   rot_data;

  // Cap each pass at 63 positions; the remainder is carried to later cycles.
  always_comb begin
    step = 6'd63;
    if (remaining_q <= ROT_WIDTH'(63)) begin
      step = remaining_q[5:0];
    end
  end

  assign remaining_next = remaining_q - ROT_WIDTH'(step);

  // Right rotation: shift the doubled vector so that the bits leaving at the
  // bottom are refilled from the top copy. This works because step < HV_LENGTH.
  assign rot_wide = {data_q, data_q} >> step;
  assign rot_data = rot_wide[HV_LENGTH-1:0];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? data_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      remaining_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q      <= in_data;
            remaining_q <= in_amount;
            state_q     <= (in_amount != '0) ? ROTATE : DONE;
          end
        end
        ROTATE: begin
          data_q      <= rot_data;
          remaining_q <= remaining_next;
          if (remaining_next == '0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HV_ROT_BUSY_CNT_EN
  logic [31:0] busy_q;

  // Only reset clears the counter; flush leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else if (state_q == ROTATE && busy_q != '1) begin
      busy_q <= busy_q + 32'd1;
    end
  end

  assign busy_cycles = busy_q;
`else
  // Without the option there is no counter and no busy_cycles port.
`endif

endmodule

// File: tb/tb_hv_rotate_sequencer.sv
module tb_hv_rotate_sequencer;

  localparam int L  = 256;
  localparam int RW = 16;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [L-1:0]  in_data;
  logic [RW-1:0] in_amount;
  logic          out_valid;
  logic          out_ready;
  logic [L-1:0]  out_data;
`ifdef HV_ROT_BUSY_CNT_EN
  logic [31:0]   busy_cycles;
  int            exp_busy;
`endif

  int errors;
  int checks;

  hv_rotate_sequencer #(.HV_LENGTH(L), .ROT_WIDTH(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef HV_ROT_BUSY_CNT_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [L-1:0] onehot(input int idx);
    logic [L-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Issue a request with in_data = 1 and wait for the result. exp_n is the
  // number of clock edges after the accept edge before out_valid is first seen.
  // hold is the number of extra cycles during which out_ready stays low.
  task automatic run_req(input string tag, input int amount, input int exp_bit,
                         input int exp_n, input int hold);
    int cnt;
    logic [L-1:0] exp_d;
    logic stable;
    exp_d = onehot(exp_bit);
    @(negedge clk);
    chk({tag, " in_ready idle"}, L'(in_ready), L'(1));
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = L'(1);
    in_amount = RW'(amount);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt = 0;
    @(negedge clk);
    if (exp_n > 0) chk({tag, " in_ready busy"}, L'(in_ready), L'(0));
    while (!out_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " latency"}, L'(cnt), L'(exp_n));
    chk({tag, " out_data"}, out_data, exp_d);
`ifdef HV_ROT_BUSY_CNT_EN
    exp_busy += exp_n;
    chk({tag, " busy_cycles"}, L'(busy_cycles), L'(exp_busy));
`endif
    if (hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== exp_d || in_ready !== 1'b0) stable = 1'b0;
      end
      chk({tag, " held stable"}, L'(stable), L'(1));
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, " back to idle"}, L'({in_ready, out_valid}), L'(2'b10));
  endtask

  initial begin
    logic seen;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amount = '0;
    out_ready = 1'b1;
`ifdef HV_ROT_BUSY_CNT_EN
    exp_busy  = 0;
`endif
    #12;
    chk("reset in_ready", L'(in_ready), L'(1));
    chk("reset out_valid", L'(out_valid), L'(0));
    chk("reset out_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req("amt1",   1,   255, 1, 0);
    run_req("amt64",  64,  192, 2, 0);
    run_req("amt300", 300, 212, 5, 0);
    run_req("amt0",   0,   0,   0, 0);
    run_req("bp63",   63,  193, 1, 5);

    // Flush in ROTATE cycle 3 of a long request.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = L'(1);
    in_amount = RW'(1000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort pre-flush busy", L'({in_ready, out_valid}), L'(2'b00));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
`ifdef HV_ROT_BUSY_CNT_EN
    exp_busy += 3;
`endif
    @(negedge clk);
    chk("abort idle", L'({in_ready, out_valid}), L'(2'b10));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort no out_valid", L'(seen), L'(0));

    // A request in the same cycle as flush is ignored.
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_amount = RW'(5);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush ignores req", L'({in_ready, out_valid}), L'(2'b10));

    run_req("after flush amt2", 2, 254, 1, 0);

    // Asynchronous reset in the middle of ROTATE.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = L'(1);
    in_amount = RW'(1000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid rotate busy", L'(in_ready), L'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst in_ready", L'(in_ready), L'(1));
    chk("async rst out_valid", L'(out_valid), L'(0));
    chk("async rst out_data", out_data, '0);
`ifdef HV_ROT_BUSY_CNT_EN
    exp_busy = 0;
    chk("async rst busy", L'(busy_cycles), L'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    chk("post rst stays idle", L'(seen), L'(0));

    run_req("post rst amt1", 1, 255, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
